// File: rtl/n64_pkg.sv
// n64_pkg: shared types and constants for the N64 command receiver.
//   cmd_kind_e    - decoded command kind driven on cmd_kind
//   st_e          - receiver FSM states
//   CMD_*         - raw command byte values
//   LEN_*         - expected data-byte counts per command
//   RUMBLE_ADDR   - pak address bits [15:5] of the rumble motor register
//   n64_addr_crc  - 5-bit pak address CRC (poly 0x15, init 0, 5 flush bits)
//   n64_decode    - command byte to cmd_kind_e
package n64_pkg;

  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_INFO   = 3'd1,
    K_POLL   = 3'd2,
    K_PAK_RD = 3'd3,
    K_PAK_WR = 3'd4,
    K_UNK    = 3'd7
  } cmd_kind_e;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} st_e;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] CMD_WR    = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam logic [8:0] LEN_SHORT = 9'd1;
  localparam logic [8:0] LEN_RD    = 9'd3;
  localparam logic [8:0] LEN_WR    = 9'd35;

  localparam logic [10:0] RUMBLE_ADDR = 11'h600;

  // Augmented long division: 11 address bits then 5 zero flush bits.
  function automatic logic [4:0] n64_addr_crc(input logic [10:0] a);
    logic [4:0]  c;
    logic [15:0] s;
    c = '0;
    s = {a, 5'b0};
    for (int i = 15; i >= 0; i--) begin
      if (c[4]) c = {c[3:0], s[i]} ^ 5'h15;
      else      c = {c[3:0], s[i]};
    end
    return c;
  endfunction

  function automatic cmd_kind_e n64_decode(input logic [7:0] b);
    case (b)
      CMD_INFO, CMD_RESET: return K_INFO;
      CMD_POLL:            return K_POLL;
      CMD_RD:              return K_PAK_RD;
      CMD_WR:              return K_PAK_WR;
      default:             return K_UNK;
    endcase
  endfunction

endpackage

// File: rtl/n64_line_filter.sv
// n64_line_filter: synchroniser chain plus glitch filter for the N64 line.
//   clk, rst  - clock, synchronous active-high reset
//   data_in   - raw asynchronous line
//   fl        - filtered line; follows the synchronised line only after it
//               has differed for GLITCH_CYCLES consecutive cycles
module n64_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic fl
);

  localparam logic [CNT_W-1:0] GL_LIM = CNT_W'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       gl_cnt_q, gl_cnt_d;
  logic                   fl_q, fl_d;
  logic                   s;

  assign s  = sync_q[SYNC_STAGES-1];
  assign fl = fl_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], data_in};
    fl_d     = fl_q;
    gl_cnt_d = '0;
    // Count consecutive disagreeing cycles; a run shorter than
    // GLITCH_CYCLES resets the count and never reaches fl.
    if (s != fl_q) begin
      if (gl_cnt_q >= GL_LIM) fl_d = s;
      else                    gl_cnt_d = gl_cnt_q + 1'b1;
    end
  end

  // Idle line is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      gl_cnt_q <= '0;
      fl_q     <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      gl_cnt_q <= gl_cnt_d;
      fl_q     <= fl_d;
    end
  end

endmodule

// File: rtl/n64_cmd_rx.sv
// n64_cmd_rx: N64 console-to-controller command receiver.
//   clk, rst            - clock, synchronous active-high reset
//   data_in             - raw N64 data line (asynchronous)
//   cmd_valid           - one-cycle strobe at frame end, qualifies cmd_*/frame_err
//   cmd_kind/byte/addr  - decoded kind, raw command byte, pak address
//   frame_err           - length, alignment, overflow or address CRC error
//   pay_valid/data/idx  - per-byte PAK_WRITE payload stream
//   rumble              - rumble motor state
// Build option: define ADDR_CRC_EN to check the pak address CRC.
module n64_cmd_rx
  import n64_pkg::*;
#(
  parameter int BIT_THRESH    = 80,
  parameter int GLITCH_CYCLES = 4,
  parameter int IDLE_CYCLES   = 200,
  parameter int CNT_W         = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  output logic        cmd_valid,
  output logic [2:0]  cmd_kind,
  output logic [7:0]  cmd_byte,
  output logic [15:0] cmd_addr,
  output logic        frame_err,
  output logic        pay_valid,
  output logic [7:0]  pay_data,
  output logic [4:0]  pay_idx,
  output logic        rumble
);

  localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [8:0]       MAX_BITS = 9'd281;  // 35 bytes + stop
  localparam logic [8:0]       BIT_SAT  = 9'd282;

  logic fl, fl_prev_q, fall, rise, frame_end;
  st_e  state_q, state_d;

  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [8:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d, fr_byte_q, fr_byte_d, fr_pay0_q, fr_pay0_d;
  logic [15:0]      fr_addr_q, fr_addr_d;
  logic [5:0]       idx;
  logic             bit_v;

  logic             cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
  cmd_kind_e        cmd_kind_q, cmd_kind_d, kind;
  logic [7:0]       cmd_byte_q, cmd_byte_d, pay_data_q, pay_data_d;
  logic [15:0]      cmd_addr_q, cmd_addr_d;
  logic             pay_valid_q, pay_valid_d, rumble_q, rumble_d;
  logic [4:0]       pay_idx_q, pay_idx_d;
  logic [8:0]       nbytes, bm1;
  logic             len_ok, crc_bad, is_pak;

  n64_line_filter #(
    .SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES), .CNT_W(CNT_W)
  ) u_filt (
    .clk(clk), .rst(rst), .data_in(data_in), .fl(fl)
  );

  assign fall = fl_prev_q & ~fl;
  assign rise = ~fl_prev_q & fl;
  // A falling edge beats the idle timeout.
  assign frame_end = (state_q == S_HIGH) && !fall && (hi_cnt_q >= IDLE_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fall) state_d = S_LOW;
      S_LOW:  if (rise) state_d = S_HIGH;
      S_HIGH: if (fall) state_d = S_LOW;
              else if (frame_end) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit capture and byte assembly
  always_comb begin
    lo_cnt_d    = lo_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    fr_byte_d   = fr_byte_q;
    fr_addr_d   = fr_addr_q;
    fr_pay0_d   = fr_pay0_q;
    pay_valid_d = 1'b0;
    pay_data_d  = pay_data_q;
    pay_idx_d   = pay_idx_q;
    bit_v       = !(lo_cnt_q > BIT_LIM);
    idx         = bit_cnt_q[8:3] - 6'd1;
    case (state_q)
      S_IDLE: if (fall) begin
        lo_cnt_d  = CNT_W'(1);
        bit_cnt_d = '0;
        sh_d      = '0;
        fr_byte_d = '0;
        fr_addr_d = '0;
        fr_pay0_d = '0;
      end
      S_LOW: if (rise) begin
        hi_cnt_d = CNT_W'(1);
        if (bit_cnt_q < BIT_SAT) begin
          // A byte is committed by the bit after its 8th, so the trailing
          // stop bit never lands in a data register.
          if (bit_cnt_q[2:0] == 3'd0 && bit_cnt_q != '0) begin
            case (idx)
              6'd0: fr_byte_d = sh_q;
              6'd1: fr_addr_d[15:8] = sh_q;
              6'd2: fr_addr_d[7:0]  = sh_q;
              default: if (fr_byte_q == CMD_WR) begin
                pay_valid_d = 1'b1;
                pay_data_d  = sh_q;
                pay_idx_d   = 5'(idx - 6'd3);
                if (idx == 6'd3) fr_pay0_d = sh_q;
              end
            endcase
          end
          sh_d      = {sh_q[6:0], bit_v};
          bit_cnt_d = bit_cnt_q + 9'd1;
        end
      end else if (lo_cnt_q != CNT_MAX) begin
        lo_cnt_d = lo_cnt_q + 1'b1;
      end
      S_HIGH: if (fall) lo_cnt_d = CNT_W'(1);
              else if (hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
      default: ;
    endcase
  end

  // Frame evaluation; results are registered so they appear in DONE.
  always_comb begin
    bm1     = bit_cnt_q - 9'd1;
    nbytes  = bm1 >> 3;
    kind    = n64_decode(fr_byte_q);
    is_pak  = (kind == K_PAK_RD) || (kind == K_PAK_WR);
    case (kind)
      K_INFO, K_POLL: len_ok = (nbytes == LEN_SHORT);
      K_PAK_RD:       len_ok = (nbytes == LEN_RD);
      K_PAK_WR:       len_ok = (nbytes == LEN_WR);
      default:        len_ok = 1'b1;
    endcase
`ifdef ADDR_CRC_EN
    crc_bad = is_pak && (fr_addr_q[4:0] != n64_addr_crc(fr_addr_q[15:5]));
`else
    crc_bad = 1'b0;
`endif
    cmd_valid_d = 1'b0;
    cmd_kind_d  = cmd_kind_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_addr_d  = cmd_addr_q;
    frame_err_d = frame_err_q;
    rumble_d    = rumble_q;
    if (frame_end && bit_cnt_q != '0) begin
      cmd_valid_d = 1'b1;
      cmd_kind_d  = kind;
      cmd_byte_d  = fr_byte_q;
      cmd_addr_d  = is_pak ? fr_addr_q : 16'h0;
      frame_err_d = (bm1[2:0] != 3'd0) || (bit_cnt_q > MAX_BITS) || !len_ok || crc_bad;
      if (kind == K_PAK_WR && !frame_err_d && fr_addr_q[15:5] == RUMBLE_ADDR)
        rumble_d = (fr_pay0_q != 8'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_prev_q   <= 1'b1;
      lo_cnt_q    <= '0;
      hi_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      fr_byte_q   <= '0;
      fr_addr_q   <= '0;
      fr_pay0_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_kind_q  <= K_NONE;
      cmd_byte_q  <= '0;
      cmd_addr_q  <= '0;
      frame_err_q <= 1'b0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_idx_q   <= '0;
      rumble_q    <= 1'b0;
    end else begin
      fl_prev_q   <= fl;
      lo_cnt_q    <= lo_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      fr_byte_q   <= fr_byte_d;
      fr_addr_q   <= fr_addr_d;
      fr_pay0_q   <= fr_pay0_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_kind_q  <= cmd_kind_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_addr_q  <= cmd_addr_d;
      frame_err_q <= frame_err_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_idx_q   <= pay_idx_d;
      rumble_q    <= rumble_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_kind  = cmd_kind_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_addr  = cmd_addr_q;
  assign frame_err = frame_err_q;
  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign pay_idx   = pay_idx_q;
  assign rumble    = rumble_q;

endmodule
